// File: rtl/rcb_alloc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rcb_alloc : per-output round-robin switch allocator; a grant is held until the owner releases
// Revision  : 1.0
// ----------------------------------------------------------------------------
module rcb_alloc #(
   parameter int NN = 5,
   parameter int MN = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NN-1:0]          req_i,
   input  logic [NN-1:0][MN-1:0]  dest_i,
   input  logic [NN-1:0]          rel_i,
   output logic [NN-1:0]          gnt_o,
   output logic [MN-1:0][NN-1:0]  cfg_o
);

   localparam int IW = (NN > 1) ? $clog2(NN) : 1;

   typedef enum logic [0:0] {
      S_FREE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t                 state_q [MN];
   logic [IW-1:0]          owner_q [MN];
   logic [IW-1:0]          ptr_q   [MN];
   logic [IW-1:0]          ptr_d   [MN];
   logic [MN-1:0][NN-1:0]  cfg_q;
   logic [NN-1:0]          gnt_q;

   logic [MN-1:0][NN-1:0]  w_cand;
   logic [MN-1:0]          w_found;
   logic [IW-1:0]          w_win   [MN];

   // A connected input never competes, so a held req/dest cannot steal a second output.
   always_comb begin
      for (int i = 0; i < MN; i++) begin
         for (int k = 0; k < NN; k++) begin
            w_cand[i][k] = req_i[k] && !gnt_q[k] && (dest_i[k] == (MN'(1) << i));
         end
      end
   end

   always_comb begin
      int idx;
      idx = 0;
      for (int i = 0; i < MN; i++) begin
         w_found[i] = 1'b0;
         w_win[i]   = '0;
         for (int off = 0; off < NN; off++) begin
            idx = (int'(ptr_q[i]) + off) % NN;
            if (!w_found[i] && w_cand[i][idx]) begin
               w_found[i] = 1'b1;
               w_win[i]   = IW'(idx);
            end
         end
         ptr_d[i] = IW'((int'(w_win[i]) + 1) % NN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MN; i++) begin
            state_q[i] <= S_FREE;
            owner_q[i] <= '0;
            ptr_q[i]   <= '0;
         end
         cfg_q <= '0;
         gnt_q <= '0;
      end else begin
         for (int i = 0; i < MN; i++) begin
            case (state_q[i])
               S_FREE: begin
                  if (w_found[i]) begin
                     state_q[i]            <= S_BUSY;
                     owner_q[i]            <= w_win[i];
                     ptr_q[i]              <= ptr_d[i];
                     cfg_q[i][w_win[i]]    <= 1'b1;
                     gnt_q[w_win[i]]       <= 1'b1;
                  end
               end
               // A busy output never arbitrates, giving one dead cycle after each release.
               S_BUSY: begin
                  if (rel_i[owner_q[i]]) begin
                     state_q[i]            <= S_FREE;
                     cfg_q[i]              <= '0;
                     gnt_q[owner_q[i]]     <= 1'b0;
                  end
               end
               default: state_q[i] <= S_FREE;
            endcase
         end
      end
   end

   assign gnt_o = gnt_q;
   assign cfg_o = cfg_q;

   generate
      for (genvar gi = 0; gi < MN; gi++) begin : g_row_chk
         a_row_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(cfg_q[gi]));
      end
      for (genvar gk = 0; gk < NN; gk++) begin : g_col_chk
         logic [MN-1:0] w_col;
         for (genvar gm = 0; gm < MN; gm++) begin : g_col_bit
            assign w_col[gm] = cfg_q[gm][gk];
         end
         a_col_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_col));
         a_gnt_match:  assert property (@(posedge clk) disable iff (rst) gnt_q[gk] == (|w_col));
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rcb_alloc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rcb_alloc : directed and random stimulus checked against an ownership-table model
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_rcb_alloc;
   localparam int NN = 5;
   localparam int MN = 5;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NN-1:0]         req_r  = '0;
   logic [NN-1:0]         rel_r  = '0;
   logic [NN-1:0][MN-1:0] dest_r = '0;
   logic [NN-1:0]         gnt_o;
   logic [MN-1:0][NN-1:0] cfg_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: which input owns each output (-1 = free) and the round-robin start point.
   int own  [MN];
   int mptr [MN];
   int mk;
   logic [NN-1:0] conn;
   logic [MN-1:0] oh;

   always #5 clk = ~clk;

   rcb_alloc #(.NN(NN), .MN(MN)) dut (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req_r),
      .dest_i (dest_r),
      .rel_i  (rel_r),
      .gnt_o  (gnt_o),
      .cfg_o  (cfg_o)
   );

   function automatic logic [NN-1:0] m_gnt();
      logic [NN-1:0] g;
      g = '0;
      for (int i = 0; i < MN; i++) if (own[i] >= 0) g[own[i]] = 1'b1;
      return g;
   endfunction

   function automatic logic [MN-1:0][NN-1:0] m_cfg();
      logic [MN-1:0][NN-1:0] c;
      c = '0;
      for (int i = 0; i < MN; i++) if (own[i] >= 0) c[i][own[i]] = 1'b1;
      return c;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MN; i++) begin
            own[i]  = -1;
            mptr[i] = 0;
         end
      end else begin
         conn = m_gnt();
         for (int i = 0; i < MN; i++) begin
            if (own[i] >= 0) begin
               if (rel_r[own[i]]) own[i] = -1;
            end else begin
               oh = '0;
               oh[i] = 1'b1;
               for (int off = 0; off < NN; off++) begin
                  mk = (mptr[i] + off) % NN;
                  if (own[i] < 0 && req_r[mk] && dest_r[mk] == oh && !conn[mk]) begin
                     own[i]  = mk;
                     mptr[i] = (mk + 1) % NN;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!rst) begin
         chk("cycle gnt", 32'(gnt_o), 32'(m_gnt()));
         chk("cycle cfg", 32'(cfg_o), 32'(m_cfg()));
      end
   endtask

   task automatic clr();
      req_r  = '0;
      rel_r  = '0;
      dest_r = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("reset gnt", 32'(gnt_o), 32'd0);
      chk("reset cfg", 32'(cfg_o), 32'd0);
      chk("model reset gnt", 32'(m_gnt()), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      tick();
   endtask

   initial begin
      int exp_seq [4];
      int gseq [$];
      int gap [$];
      int held [NN];
      int prev_own, zero_run, cur, r;
      logic [NN-1:0] g;

      exp_seq = '{0, 1, 4, 0};
      clr();

      // Reset then idle
      do_reset();
      repeat (3) tick();
      chk("idle gnt", 32'(gnt_o), 32'd0);

      // Single grant and release
      req_r[2] = 1'b1; dest_r[2] = 5'b01000;
      tick();
      chk("s2 cfg3", 32'(cfg_o[3]), 32'b00100);
      chk("s2 gnt", 32'(gnt_o), 32'b00100);
      chk("s2 model gnt", 32'(m_gnt()), 32'b00100);
      req_r[2] = 1'b0; rel_r[2] = 1'b1;
      tick();
      rel_r[2] = 1'b0;
      chk("s2 rel cfg3", 32'(cfg_o[3]), 32'd0);
      chk("s2 rel gnt", 32'(gnt_o), 32'd0);

      // Round-robin contention on output 1
      clr();
      do_reset();
      for (int k = 0; k < NN; k++) held[k] = 0;
      foreach (exp_seq[j]) begin
         req_r[exp_seq[j]] = 1'b1;
         dest_r[exp_seq[j]] = 5'b00010;
      end
      prev_own = -1; zero_run = 0;
      for (int c = 0; c < 40 && gseq.size() < 4; c++) begin
         tick();
         chk("s3 row onehot", 32'($onehot0(cfg_o[1])), 32'd1);
         if (cfg_o[1] != '0) begin
            cur = -1;
            for (int k = 0; k < NN; k++) if (cfg_o[1][k]) cur = k;
            if (prev_own < 0) begin
               gseq.push_back(cur);
               if (gseq.size() > 1) gap.push_back(zero_run);
            end
            prev_own = cur; zero_run = 0;
         end else begin
            prev_own = -1; zero_run++;
         end
         g = m_gnt();
         for (int k = 0; k < NN; k++) begin
            if (k == 0 || k == 1 || k == 4) begin
               if (rel_r[k]) begin
                  rel_r[k] = 1'b0; req_r[k] = 1'b1;
               end else if (g[k]) begin
                  req_r[k] = 1'b0;
                  held[k]++;
                  if (held[k] == 3) begin rel_r[k] = 1'b1; held[k] = 0; end
               end
            end
         end
      end
      chk("s3 grant count", 32'(gseq.size()), 32'd4);
      for (int j = 0; j < gseq.size() && j < 4; j++) chk("s3 grant order", 32'(gseq[j]), 32'(exp_seq[j]));
      for (int j = 0; j < gap.size(); j++) chk("s3 dead cycles", 32'(gap[j]), 32'd1);

      // Parallel outputs
      clr();
      do_reset();
      req_r[0] = 1'b1; dest_r[0] = 5'b00100;
      req_r[3] = 1'b1; dest_r[3] = 5'b10000;
      tick();
      chk("s4 gnt", 32'(gnt_o), 32'b01001);
      chk("s4 cfg2", 32'(cfg_o[2]), 32'b00001);
      chk("s4 cfg4", 32'(cfg_o[4]), 32'b01000);

      // Release/request collision on output 1
      clr();
      do_reset();
      req_r[0] = 1'b1; dest_r[0] = 5'b00010;
      tick();
      chk("s5 cfg1 busy", 32'(cfg_o[1]), 32'b00001);
      req_r[0] = 1'b0; rel_r[0] = 1'b1;
      req_r[2] = 1'b1; dest_r[2] = 5'b00010;
      tick();
      rel_r[0] = 1'b0;
      chk("s5 cfg1 dead", 32'(cfg_o[1]), 32'd0);
      tick();
      chk("s5 cfg1 regrant", 32'(cfg_o[1]), 32'b00100);
      chk("s5 gnt", 32'(gnt_o), 32'b00100);

      // Illegal destinations never granted
      clr();
      do_reset();
      req_r[1] = 1'b1; dest_r[1] = 5'b00110;
      repeat (3) tick();
      chk("s6 multi-hot gnt", 32'(gnt_o), 32'd0);
      dest_r[1] = 5'b00000;
      repeat (3) tick();
      chk("s6 zero dest gnt", 32'(gnt_o), 32'd0);

      // Reset during BUSY restores pointer 0
      clr();
      req_r[3] = 1'b1; dest_r[3] = 5'b00001;
      tick();
      chk("s6 busy cfg0", 32'(cfg_o[0]), 32'b01000);
      clr();
      do_reset();
      req_r[1] = 1'b1; dest_r[1] = 5'b00001;
      req_r[4] = 1'b1; dest_r[4] = 5'b00001;
      tick();
      chk("s6 post-reset cfg0", 32'(cfg_o[0]), 32'b00010);

      // Randomized traffic
      clr();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < NN; k++) begin
            req_r[k] = ($urandom_range(0, 2) != 0);
            rel_r[k] = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      dest_r[k] = '0;
            else if (r == 1) dest_r[k] = MN'($urandom);
            else             dest_r[k] = MN'(1) << $urandom_range(0, MN - 1);
         end
         if (c == 300) do_reset();
         else tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
